// File: rtl/instr_encoder_loader.sv
// Packs MIPS fields into 32-bit words, buffers them in a small FIFO and streams
// them into IMEM over a valid/ready write port from a programmed base address.

module instr_field_pack (
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] immediate,
  input  logic [25:0] address,
  output logic [31:0] word,
  output logic        illegal
);
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (fmt)
      2'd0:    word = {opcode, rs, rt, rd, shamt, funct};
      2'd1:    word = {opcode, rs, rt, immediate};
      2'd2:    word = {opcode, address};
      default: illegal = 1'b1;  // encodes as nop, still written
    endcase
  end
endmodule

module instr_encoder_loader #(
  parameter int IMEM_ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [IMEM_ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]                 length,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 fmt,
  input  logic [5:0]                 opcode,
  input  logic [4:0]                 rs,
  input  logic [4:0]                 rt,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 shamt,
  input  logic [5:0]                 funct,
  input  logic [15:0]                immediate,
  input  logic [25:0]                address,
  output logic                       imem_we,
  input  logic                       imem_ready,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       fmt_err
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state;
  logic [31:0]                mem [FIFO_DEPTH];
  logic [PW-1:0]              head, tail;
  logic [CW-1:0]              count;
  logic [IMEM_ADDR_WIDTH-1:0] wptr;
  logic [7:0]                 len_q, acc_cnt, wr_cnt;
  logic [31:0]                enc_word;
  logic                       enc_illegal;
  logic                       full, empty, accept, wdone;

  instr_field_pack u_pack (
    .fmt       (fmt),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .immediate (immediate),
    .address   (address),
    .word      (enc_word),
    .illegal   (enc_illegal)
  );

  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  // in_ready looks only at registered state, never at imem_ready
  assign in_ready   = (state == RUN) && !full && (acc_cnt < len_q);
  assign accept     = in_valid && in_ready;
  assign imem_we    = !empty;
  assign wdone      = imem_we && imem_ready;
  assign imem_addr  = wptr;
  assign imem_wdata = empty ? 32'h0 : mem[head];
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (accept) mem[tail] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      wptr    <= '0;
      len_q   <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      fmt_err <= 1'b0;
    end else begin
      if (accept) begin
        tail    <= tail + 1'b1;
        acc_cnt <= acc_cnt + 8'd1;
        if (enc_illegal) fmt_err <= 1'b1;
      end
      if (wdone) begin
        head   <= head + 1'b1;
        wptr   <= wptr + 1'b1;
        wr_cnt <= wr_cnt + 8'd1;
      end
      case ({accept, wdone})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      case (state)
        IDLE: if (start) begin
          fmt_err <= 1'b0;
          wptr    <= base_addr;
          len_q   <= length;
          acc_cnt <= '0;
          wr_cnt  <= '0;
          state   <= (length == 8'd0) ? DONE : RUN;
        end
        RUN:     if (wdone && (8'(wr_cnt + 8'd1) == len_q)) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized and directed bench for instr_encoder_loader against a queue-based
// behavioural model, plus literal checks for the documented scenarios.

module tb_instr_encoder_loader;
  localparam int AW = 8;
  localparam int FD = 4;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] ad;
  } fld_t;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 0, rst = 1, start = 0, in_valid = 0, imem_ready = 0;
  logic [AW-1:0] base_addr = '0;
  logic [7:0] length = '0;
  logic [1:0] fmt = '0;
  logic [5:0] opcode = '0, funct = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] immediate = '0;
  logic [25:0] address = '0;
  logic in_ready, imem_we, busy, done, fmt_err;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;

  int checks = 0, failures = 0, cyc = 0;
  bit rand_rdy = 0;
  wr_t wlog[$];

  // model state
  int m_state = 0;  // 0 idle, 1 loading, 2 finished
  logic [31:0] q[$];
  int unsigned m_wptr = 0, m_len = 0, m_acc = 0, m_wr = 0;
  bit m_err = 0, m_ok = 0;

  instr_encoder_loader #(.IMEM_ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .immediate(immediate), .address(address), .imem_we(imem_we),
    .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input int unsigned f, op, s, t, d, sa, fn, im, ad);
    int unsigned w;
    case (f)
      0: w = op * 2**26 + s * 2**21 + t * 2**16 + d * 2**11 + sa * 2**6 + fn;
      1: w = op * 2**26 + s * 2**21 + t * 2**16 + im;
      2: w = op * 2**26 + ad;
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] enc_f(input fld_t x);
    return enc(x.fmt, x.op, x.rs, x.rt, x.rd, x.sh, x.fn, x.imm, x.ad);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // model advances on each rising edge from the inputs only
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_state = 0; q.delete(); m_wptr = 0; m_len = 0; m_acc = 0; m_wr = 0;
      m_err = 0; m_ok = 1;
    end else begin
      bit acc, wd;
      int ns;
      ns  = m_state;
      acc = in_valid && m_state == 1 && q.size() < FD && m_acc < m_len;
      wd  = q.size() > 0 && imem_ready;
      if (wd) begin
        void'(q.pop_front());
        m_wptr = (m_wptr + 1) % (1 << AW);
        m_wr++;
        if (m_wr == m_len) ns = 2;
      end
      if (acc) begin
        q.push_back(enc(fmt, opcode, rs, rt, rd, shamt, funct, immediate, address));
        m_acc++;
        if (fmt == 2'd3) m_err = 1;
      end
      if (m_state == 0 && start) begin
        m_err = 0; m_wptr = base_addr; m_len = length; m_acc = 0; m_wr = 0;
        ns = (length == 0) ? 2 : 1;
      end else if (m_state == 2) ns = 0;
      m_state = ns;
    end
  end

  // compare process: every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    cyc++;
    if (m_ok) begin
      chk("in_ready", 32'(in_ready), 32'(m_state == 1 && q.size() < FD && m_acc < m_len));
      chk("imem_we", 32'(imem_we), 32'(q.size() > 0));
      chk("imem_addr", 32'(imem_addr), m_wptr);
      if (q.size() > 0) chk("imem_wdata", imem_wdata, q[0]);
      chk("busy", 32'(busy), 32'(m_state != 0));
      chk("done", 32'(done), 32'(m_state == 2));
      chk("fmt_err", 32'(fmt_err), 32'(m_err));
      if (imem_we && imem_ready) wlog.push_back('{addr: imem_addr, data: imem_wdata, cyc: cyc});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) imem_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic apply(input fld_t f);
    fmt = f.fmt; opcode = f.op; rs = f.rs; rt = f.rt; rd = f.rd; shamt = f.sh;
    funct = f.fn; immediate = f.imm; address = f.ad;
  endtask

  task automatic send(input fld_t f);
    int n;
    n = 0;
    apply(f);
    in_valid = 1;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (n >= 200) chk("accept_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [7:0] n);
    start = 1; base_addr = b; length = n;
    tick();
    start = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 400) begin tick(); n++; end
    chk("done_timeout", 32'(done), 32'd1);
    tick();
  endtask

  function automatic fld_t rnd_fld(input bit allow_bad);
    fld_t f;
    f = fld_t'({$urandom, $urandom, $urandom});
    f.fmt = 2'($urandom_range(0, allow_bad ? 3 : 2));
    return f;
  endfunction

  function automatic fld_t mk(input int f, op, s, t, d, sa, fn, im, ad);
    fld_t x;
    x.fmt = 2'(f); x.op = 6'(op); x.rs = 5'(s); x.rt = 5'(t); x.rd = 5'(d);
    x.sh = 5'(sa); x.fn = 6'(fn); x.imm = 16'(im); x.ad = 26'(ad);
    return x;
  endfunction

  fld_t items[6];
  int k, len, base0;
  bit acc;

  initial begin
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_imem_we", 32'(imem_we), 0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fmt_err", 32'(fmt_err), 0);
    rst = 0;
    tick();

    // R-type single write
    imem_ready = 1; wlog.delete();
    pulse_start(8'h10, 8'd1);
    chk("r_in_ready_after_start", 32'(in_ready), 1);
    send(mk(0, 0, 1, 2, 3, 0, 'h20, 'hFFFF, 'h3FFFFFF));
    wait_done();
    chk("r_nwrites", wlog.size(), 1);
    if (wlog.size() >= 1) begin
      chk("r_addr", wlog[0].addr, 32'h10);
      chk("r_data", wlog[0].data, 32'h00221820);
    end

    // I then J back to back
    wlog.delete();
    pulse_start(8'h00, 8'd2);
    send(mk(1, 'h08, 0, 8, 31, 31, 63, 5, 0));
    send(mk(2, 'h02, 31, 31, 31, 31, 63, 'hFFFF, 'h100));
    wait_done();
    chk("ij_nwrites", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("i_addr", wlog[0].addr, 0);
      chk("i_data", wlog[0].data, 32'h20080005);
      chk("j_addr", wlog[1].addr, 1);
      chk("j_data", wlog[1].data, 32'h08000100);
      chk("ij_consecutive", 32'(wlog[1].cyc - wlog[0].cyc), 1);
    end

    // backpressure: FIFO fills to depth, head held stable
    wlog.delete(); imem_ready = 0;
    for (int i = 0; i < 6; i++) items[i] = rnd_fld(0);
    pulse_start(8'h40, 8'd6);
    k = 0; apply(items[0]); in_valid = 1;
    for (int c = 0; c < 10; c++) begin
      acc = in_ready;
      tick();
      if (acc) k++;
      apply(items[k < 6 ? k : 5]);
      if (imem_we) begin
        chk("bp_addr_stable", 32'(imem_addr), 32'h40);
        chk("bp_data_stable", imem_wdata, enc_f(items[0]));
      end
    end
    chk("bp_accepts", k, 4);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    imem_ready = 1;
    for (int c = 0; c < 50 && k < 6; c++) begin
      acc = in_ready && in_valid;
      tick();
      if (acc) k++;
      apply(items[k < 6 ? k : 5]);
    end
    in_valid = 0;
    wait_done();
    chk("bp_nwrites", wlog.size(), 6);
    for (int i = 0; i < 6 && i < wlog.size(); i++) begin
      chk("bp_order_addr", wlog[i].addr, 32'(8'h40 + i));
      chk("bp_order_data", wlog[i].data, enc_f(items[i]));
    end

    // address wrap and illegal format
    wlog.delete();
    pulse_start(8'hFF, 8'd2);
    send(mk(1, 'h23, 4, 5, 0, 0, 0, 'h1234, 0));
    send(mk(3, 'h3F, 31, 31, 31, 31, 63, 'hFFFF, 'h3FFFFFF));
    wait_done();
    chk("wrap_nwrites", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      chk("wrap_addr0", wlog[0].addr, 32'hFF);
      chk("wrap_data0", wlog[0].data, 32'h8C851234);
      chk("wrap_addr1", wlog[1].addr, 32'h00);
      chk("wrap_data1", wlog[1].data, 32'h0);
    end
    tick(); tick();
    chk("fmt_err_sticky", 32'(fmt_err), 1);

    // length 0: done next cycle, no writes, clears fmt_err
    wlog.delete();
    pulse_start(8'h33, 8'd0);
    chk("len0_done", 32'(done), 1);
    chk("len0_fmt_err_clr", 32'(fmt_err), 0);
    tick();
    chk("len0_busy_fall", 32'(busy), 0);
    tick(); tick();
    chk("len0_nwrites", wlog.size(), 0);

    // start during RUN is ignored
    wlog.delete();
    pulse_start(8'h20, 8'd3);
    send(rnd_fld(0));
    pulse_start(8'h80, 8'd1);
    send(rnd_fld(0));
    send(rnd_fld(0));
    wait_done();
    chk("ign_nwrites", wlog.size(), 3);
    if (wlog.size() >= 3) chk("ign_last_addr", wlog[2].addr, 32'h22);

    // reset mid-load discards buffered words
    imem_ready = 0;
    pulse_start(8'h50, 8'd5);
    send(mk(3, 0, 0, 0, 0, 0, 0, 0, 0));
    send(rnd_fld(0));
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_imem_we", 32'(imem_we), 0);
    chk("mid_rst_imem_addr", 32'(imem_addr), 0);
    chk("mid_rst_imem_wdata", imem_wdata, 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_fmt_err", 32'(fmt_err), 0);
    wlog.delete(); imem_ready = 1;
    repeat (6) tick();
    chk("mid_rst_no_writes", wlog.size(), 0);

    // randomized loads with random IMEM backpressure
    rand_rdy = 1;
    for (int l = 0; l < 12; l++) begin
      len = $urandom_range(1, 10);
      base0 = $urandom_range(0, 255);
      pulse_start(8'(base0), 8'(len));
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        send(rnd_fld(1));
        if (i == 0 && l % 3 == 0) pulse_start(8'($urandom), 8'($urandom_range(0, 5)));
      end
      wait_done();
    end
    rand_rdy = 0; imem_ready = 1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
